// File: rtl/ttx_pkg.sv
// Shared types for the truth-table extractor: FSM states, row index type and row-to-bit mapping.
package ttx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int ROWS = 16;

  typedef logic [3:0] row_t;

  // Row 0 ({in1..in4} = 0000) lands in the MSB, matching Cello hex notation.
  function automatic row_t row_bit(row_t r);
    return 4'd15 - r;
  endfunction

endpackage

// File: rtl/ttx_sync2.sv
// Two-flop synchroniser for the asynchronous DUT output; 2-cycle latency, no backpressure.
module ttx_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/truth_table_extractor.sv
// Sweeps a 4-input DUT through all 16 rows and assembles its hex truth table; start is ignored unless idle.
// Latency t+16*(SETTLE_CYCLES+1)+1; with TTX_STABILITY_CHECK_EN each row is sampled CHECK_SAMPLES times.
module truth_table_extractor #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CHECK_SAMPLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        drive_in1,
  output logic        drive_in2,
  output logic        drive_in3,
  output logic        drive_in4,
  input  logic        dut_out,
  output logic [15:0] truth_table,
  output logic        table_valid,
  output logic        unstable
);
  import ttx_pkg::*;

  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  if (SETTLE_CYCLES < 2 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("truth_table_extractor: SETTLE_CYCLES must be in 2..255");
  end

  state_t        state;
  state_t        state_nxt;
  row_t          row;
  logic [SW-1:0] settle_cnt;
  logic          dut_sync;
  logic          settle_last;
  logic          sample_first;
  logic          sample_last;
  logic          row_last;

  ttx_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (dut_out),
    .q   (dut_sync)
  );

  assign settle_last = (settle_cnt == SW'(SETTLE_CYCLES - 1));
  assign row_last    = (row == row_t'(ROWS - 1));

  // Row register is the drive source, so the DUT inputs hold the last row while idle.
  assign {drive_in1, drive_in2, drive_in3, drive_in4} = row;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETTLE;
      SETTLE:  if (settle_last) state_nxt = SAMPLE;
      SAMPLE:  if (sample_last) state_nxt = row_last ? DONE : SETTLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    if (state != IDLE) busy = 1'b1;
    if (state == DONE) done = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row         <= '0;
      settle_cnt  <= '0;
      truth_table <= '0;
      table_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            row         <= '0;
            settle_cnt  <= '0;
            truth_table <= '0;
            table_valid <= 1'b0;
          end
        end
        SETTLE: settle_cnt <= settle_last ? '0 : settle_cnt + 1'b1;
        SAMPLE: begin
          if (sample_first) truth_table[row_bit(row)] <= dut_sync;
          if (sample_last && !row_last) row <= row + 1'b1;
        end
        DONE:    table_valid <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef TTX_STABILITY_CHECK_EN
  localparam int CW = $clog2(CHECK_SAMPLES);

  if (CHECK_SAMPLES < 2 || CHECK_SAMPLES > 8) begin : g_bad_check
    $error("truth_table_extractor: CHECK_SAMPLES must be in 2..8");
  end

  logic [CW-1:0] sample_cnt;

  assign sample_first = (sample_cnt == '0);
  assign sample_last  = (sample_cnt == CW'(CHECK_SAMPLES - 1));

  // Later samples are compared against the bit already captured from the first one.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cnt <= '0;
      unstable   <= 1'b0;
    end else begin
      if (state == IDLE && start) unstable <= 1'b0;
      if (state == SAMPLE) begin
        sample_cnt <= sample_last ? '0 : sample_cnt + 1'b1;
        if (!sample_first && (dut_sync != truth_table[row_bit(row)])) unstable <= 1'b1;
      end
    end
  end
`else
  logic unused_cfg;

  assign sample_first = 1'b1;
  assign sample_last  = 1'b1;
  assign unstable     = 1'b0;
  assign unused_cfg   = |CHECK_SAMPLES;
`endif

endmodule

// File: tb/tb_truth_table_extractor.sv
// Scoreboarded bench for truth_table_extractor: reference DUT functions, start filtering, reset abort, stability.
module tb_truth_table_extractor;

`ifdef TTX_STABILITY_CHECK_EN
  localparam int   LAT          = 16 * (4 + 3) + 1;
  localparam logic EXP_UNSTABLE = 1'b1;
`else
  localparam int   LAT          = 16 * (4 + 1) + 1;
  localparam logic EXP_UNSTABLE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        drive_in1, drive_in2, drive_in3, drive_in4;
  logic        dut_out;
  logic [15:0] truth_table;
  logic        table_valid;
  logic        unstable;

  int checks = 0;
  int errors = 0;

  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic [15:0] done_tt = '0;

  int          mode = 0;
  logic [15:0] func_tt = 16'hC248;
  logic        tog = 1'b0;
  logic [3:0]  row_drv;

  logic [15:0] exp_q[$];
  int          lat_q[$];

  truth_table_extractor #(.SETTLE_CYCLES(4), .CHECK_SAMPLES(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .drive_in1   (drive_in1),
    .drive_in2   (drive_in2),
    .drive_in3   (drive_in3),
    .drive_in4   (drive_in4),
    .dut_out     (dut_out),
    .truth_table (truth_table),
    .table_valid (table_valid),
    .unstable    (unstable)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    tog = ~tog;
  end

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_tt  = truth_table;
    end
  end

  assign row_drv = {drive_in1, drive_in2, drive_in3, drive_in4};

  // Reference circuits; mode 4 oscillates only while row 3 is applied.
  always_comb begin
    dut_out = 1'b0;
    case (mode)
      0: dut_out = func_tt[~row_drv];
      1: dut_out = 1'b1;
      2: dut_out = drive_in1;
      3: dut_out = drive_in4;
      4: dut_out = (row_drv == 4'd3) ? tog : func_tt[~row_drv];
      default: dut_out = 1'b0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [15:0] e);
    exp_q.push_back(e);
    lat_q.push_back(cyc + LAT);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int n, output bit got);
    got = 1'b0;
    for (int i = 0; i < LAT + 50; i++) begin
      tick();
      if (done_cnt > n) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    checks++;
    if ({busy, done, row_drv, table_valid, unstable, truth_table} !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b row=%0d tv=%b unst=%b tt=%h want all zero",
               busy, done, row_drv, table_valid, unstable, truth_table);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_stability();
    int n0;
    bit got;
    logic [15:0] e;
    int l;
    mode    = 4;
    func_tt = 16'hC248;
    n0      = done_cnt;
    launch(16'hC248);
    wait_done(n0, got);
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL stab_timeout no done within %0d cycles", LAT + 50);
    end
    checks++;
    if ((done_tt & 16'hEFFF) !== (e & 16'hEFFF)) begin
      errors++;
      $display("FAIL stab_table got %h want %h (row 3 masked)", done_tt, e);
    end
    checks++;
    if (done_cyc !== l) begin
      errors++;
      $display("FAIL stab_latency got cycle %0d want %0d", done_cyc, l);
    end
    checks++;
    if (unstable !== EXP_UNSTABLE) begin
      errors++;
      $display("FAIL stab_flag got %b want %b", unstable, EXP_UNSTABLE);
    end
  endtask

  task automatic test_patterns();
    logic [15:0] pat_tt[4] = '{16'hC248, 16'hFFFF, 16'h00FF, 16'h5555};
    int          pat_md[4] = '{0, 1, 2, 3};
    for (int i = 0; i < 4; i++) begin
      int n0;
      bit got;
      logic [15:0] e;
      int l;
      mode    = pat_md[i];
      func_tt = 16'hC248;
      n0      = done_cnt;
      launch(pat_tt[i]);
      checks++;
      if (busy !== 1'b1 || table_valid !== 1'b0) begin
        errors++;
        $display("FAIL pat%0d_accept got busy=%b tv=%b want busy=1 tv=0", i, busy, table_valid);
      end
      wait_done(n0, got);
      e = exp_q.pop_front();
      l = lat_q.pop_front();
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL pat%0d_timeout no done within %0d cycles", i, LAT + 50);
      end
      checks++;
      if (done_tt !== e) begin
        errors++;
        $display("FAIL pat%0d_table got %h want %h", i, done_tt, e);
      end
      checks++;
      if (done_cyc !== l) begin
        errors++;
        $display("FAIL pat%0d_latency got cycle %0d want %0d", i, done_cyc, l);
      end
      checks++;
      if (table_valid !== 1'b1 || busy !== 1'b0 || unstable !== 1'b0) begin
        errors++;
        $display("FAIL pat%0d_status got tv=%b busy=%b unst=%b want 1 0 0", i, table_valid, busy, unstable);
      end
      repeat (5) tick();
      checks++;
      if (truth_table !== e || table_valid !== 1'b1 || row_drv !== 4'd15) begin
        errors++;
        $display("FAIL pat%0d_hold got tt=%h tv=%b row=%0d want tt=%h tv=1 row=15",
                 i, truth_table, table_valid, row_drv, e);
      end
    end
  endtask

  task automatic test_start_held();
    int n0;
    bit got;
    logic [15:0] e;
    int l;
    mode    = 0;
    func_tt = 16'hC248;
    n0      = done_cnt;
    exp_q.push_back(16'hC248);
    lat_q.push_back(cyc + LAT);
    start = 1'b1;
    wait_done(n0, got);
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    checks++;
    if (!got || done_tt !== e || done_cyc !== l) begin
      errors++;
      $display("FAIL held_first got done=%b tt=%h cyc=%0d want tt=%h cyc=%0d", got, done_tt, done_cyc, e, l);
    end
    // Start still high: the cycle after DONE must be IDLE before the next acceptance.
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL held_idle_gap got busy=%b want 0", busy);
    end
    exp_q.push_back(16'hC248);
    lat_q.push_back(cyc + LAT);
    repeat (20) tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n0 + 1, got);
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    checks++;
    if (!got || done_tt !== e || done_cyc !== l) begin
      errors++;
      $display("FAIL held_second got done=%b tt=%h cyc=%0d want tt=%h cyc=%0d", got, done_tt, done_cyc, e, l);
    end
    repeat (LAT + 10) tick();
    checks++;
    if (done_cnt !== n0 + 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL held_done_count got %0d busy=%b want %0d busy=0", done_cnt - n0, busy, 2);
    end
  endtask

  task automatic test_mid_reset();
    int n0;
    bit got;
    logic [15:0] e;
    int l;
    mode    = 0;
    func_tt = 16'hC248;
    n0      = done_cnt;
    launch(16'hC248);
    for (int i = 0; i < LAT && row_drv != 4'd7; i++) tick();
    checks++;
    if (row_drv !== 4'd7 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_reach_row7 got row=%0d busy=%b want row=7 busy=1", row_drv, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, row_drv, table_valid, unstable} !== '0 || truth_table !== 16'h0000) begin
      errors++;
      $display("FAIL rst_abort got busy=%b row=%0d tv=%b tt=%h want all zero", busy, row_drv, table_valid, truth_table);
    end
    exp_q.delete();
    lat_q.delete();
    repeat (LAT) tick();
    checks++;
    if (done_cnt !== n0) begin
      errors++;
      $display("FAIL rst_no_done got %0d done pulses want 0", done_cnt - n0);
    end
    launch(16'hC248);
    wait_done(n0, got);
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    checks++;
    if (!got || done_tt !== e || done_cyc !== l || table_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_resweep got done=%b tt=%h cyc=%0d tv=%b want tt=%h cyc=%0d tv=1",
               got, done_tt, done_cyc, table_valid, e, l);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    test_reset();
    test_stability();
    test_patterns();
    test_start_held();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
